// File: rtl/sniffer_capture_if.sv
// Readout port of the RX capture buffer: request address in, registered entry out.
interface sniffer_capture_if #(
  parameter int ADDR_W  = 9,
  parameter int ENTRY_W = 18
);
  // rd_en is accepted every cycle with no backpressure. Each accepted request
  // yields exactly one rd_valid pulse with rd_data on the following cycle.
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_valid;
  logic [ENTRY_W-1:0] rd_data;

  modport master (output rd_en, output rd_addr, input rd_valid, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_valid, output rd_data);
endinterface

// File: rtl/sniffer_capture.sv
// PIPE RX sniffer: zero-latency lane pass-through plus pre/post-trigger ring capture.
// Optional SNIFFER_CAPTURE_TIMESTAMP_EN stores a 32-bit cycle stamp in each entry.
module sniffer_capture #(
  parameter int DATA_W   = 16,
  parameter int CTL_W    = 2,
  parameter int DEPTH    = 512,
  parameter int PRE_TRIG = 64,
  localparam int ADDR_W  = $clog2(DEPTH),
`ifdef SNIFFER_CAPTURE_TIMESTAMP_EN
  localparam int ENTRY_W = DATA_W + CTL_W + 32
`else
  localparam int ENTRY_W = DATA_W + CTL_W
`endif
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [DATA_W-1:0] rx_data_in,
  input  logic [CTL_W-1:0]  rx_ctl_in,
  output logic [DATA_W-1:0] rx_data_out,
  output logic [CTL_W-1:0]  rx_ctl_out,
  input  logic              arm,
  input  logic              abort,
  input  logic              force_trig,
  input  logic [DATA_W-1:0] trig_data,
  input  logic [DATA_W-1:0] trig_data_mask,
  input  logic [CTL_W-1:0]  trig_ctl,
  input  logic [CTL_W-1:0]  trig_ctl_mask,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W-1:0] start_addr,
  output logic [2:0]        state_dbg,
  sniffer_capture_if.slave  rd
);

  localparam int POST_N = DEPTH - PRE_TRIG - 1;
  localparam logic [ADDR_W-1:0] PRE_A     = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  pre_cnt;
  logic [ADDR_W-1:0]  post_cnt;
  logic               wr_en;
  logic               start_cap;
  logic               trig_fire;
  logic               match;
  logic [ENTRY_W-1:0] entry;
  logic [ADDR_W-1:0]  rd_phys;
  logic [ENTRY_W-1:0] mem [DEPTH];

  assign rx_data_out = rx_data_in;
  assign rx_ctl_out  = rx_ctl_in;

  assign match = (((rx_data_in ^ trig_data) & trig_data_mask) == '0) &&
                 (((rx_ctl_in ^ trig_ctl) & trig_ctl_mask) == '0);

`ifdef SNIFFER_CAPTURE_TIMESTAMP_EN
  logic [31:0] ts;

  always_ff @(posedge clk_in) begin
    if (rst_in) ts <= '0;
    else        ts <= ts + 32'd1;
  end

  assign entry = {ts, rx_ctl_in, rx_data_in};
`else
  assign entry = {rx_ctl_in, rx_data_in};
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nx;
  end

  // abort overrides everything, including an arm in the same cycle.
  always_comb begin
    state_nx  = state;
    wr_en     = 1'b0;
    start_cap = 1'b0;
    trig_fire = 1'b0;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            start_cap = 1'b1;
            if (PRE_TRIG == 0) state_nx = S_ARMED;
            else               state_nx = S_PRE;
          end
        end
        S_PRE: begin
          wr_en = 1'b1;
          if (pre_cnt == PRE_LAST) state_nx = S_ARMED;
        end
        S_ARMED: begin
          wr_en = 1'b1;
          if (match || force_trig) begin
            trig_fire = 1'b1;
            if (POST_N == 0) state_nx = S_DONE;
            else             state_nx = S_POST;
          end
        end
        S_POST: begin
          wr_en = 1'b1;
          if (post_cnt == POST_LAST) state_nx = S_DONE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  assign busy      = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
  assign done      = (state == S_DONE);
  assign state_dbg = state;
  assign rd_phys   = start_addr + rd.rd_addr;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr      <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      triggered   <= 1'b0;
      start_addr  <= '0;
      rd.rd_valid <= 1'b0;
      rd.rd_data  <= '0;
    end else begin
      if (start_cap) begin
        wr_ptr    <= '0;
        pre_cnt   <= '0;
        post_cnt  <= '0;
        triggered <= 1'b0;
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (wr_en && state == S_PRE)  pre_cnt  <= pre_cnt + 1'b1;
      if (wr_en && state == S_POST) post_cnt <= post_cnt + 1'b1;
      // Oldest kept sample sits PRE_TRIG slots behind the trigger sample.
      if (trig_fire) begin
        triggered  <= 1'b1;
        start_addr <= wr_ptr - PRE_A;
      end
      rd.rd_valid <= rd.rd_en;
      if (rd.rd_en) rd.rd_data <= mem[rd_phys];
    end
  end

  // Buffer is not reset; a same-address read in the write cycle sees old data.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr] <= entry;
  end

endmodule

// File: tb/tb_sniffer_capture.sv
// Self-checking bench for sniffer_capture (DEPTH=16, PRE_TRIG=4), scoreboard on the read port.
module tb_sniffer_capture;
  localparam int DATA_W   = 16;
  localparam int CTL_W    = 2;
  localparam int DEPTH    = 16;
  localparam int PRE_TRIG = 4;
  localparam int AW       = 4;
  localparam int POST_N   = DEPTH - PRE_TRIG - 1;
  localparam int HN       = 4096;
`ifdef SNIFFER_CAPTURE_TIMESTAMP_EN
  localparam int EW = DATA_W + CTL_W + 32;
`else
  localparam int EW = DATA_W + CTL_W;
`endif

  logic              clk = 1'b0;
  logic              rst_in;
  logic [DATA_W-1:0] rx_data_in, rx_data_out;
  logic [CTL_W-1:0]  rx_ctl_in, rx_ctl_out;
  logic              arm, abort, force_trig;
  logic [DATA_W-1:0] trig_data, trig_data_mask;
  logic [CTL_W-1:0]  trig_ctl, trig_ctl_mask;
  logic              busy, triggered, done;
  logic [AW-1:0]     start_addr;
  logic [2:0]        state_dbg;

  sniffer_capture_if #(.ADDR_W(AW), .ENTRY_W(EW)) rd_if ();

  sniffer_capture #(
    .DATA_W(DATA_W), .CTL_W(CTL_W), .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG)
  ) dut (
    .clk_in(clk), .rst_in(rst_in),
    .rx_data_in(rx_data_in), .rx_ctl_in(rx_ctl_in),
    .rx_data_out(rx_data_out), .rx_ctl_out(rx_ctl_out),
    .arm(arm), .abort(abort), .force_trig(force_trig),
    .trig_data(trig_data), .trig_data_mask(trig_data_mask),
    .trig_ctl(trig_ctl), .trig_ctl_mask(trig_ctl_mask),
    .busy(busy), .triggered(triggered), .done(done),
    .start_addr(start_addr), .state_dbg(state_dbg),
    .rd(rd_if.slave)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int seq_base = 0;
  bit rand_mode = 1'b1;
  int last_start = 0;
  logic [EW-1:0] hist [HN];
  logic [EW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // stimulus history model: what the lane carried in each cycle
`ifdef SNIFFER_CAPTURE_TIMESTAMP_EN
  logic [31:0] tb_ts = '0;
  always @(posedge clk) tb_ts <= rst_in ? 32'd0 : tb_ts + 32'd1;
  always @(negedge clk) begin
    hist[cyc % HN] = {tb_ts, rx_ctl_in, rx_data_in};
    cyc++;
  end
`else
  always @(negedge clk) begin
    hist[cyc % HN] = {rx_ctl_in, rx_data_in};
    cyc++;
  end
`endif

  // pass-through and read-port monitors
  always @(negedge clk) begin
    check("pt_data", 64'(rx_data_out), 64'(rx_data_in));
    check("pt_ctl", 64'(rx_ctl_out), 64'(rx_ctl_in));
    if (rd_if.rd_valid) begin
      if (exp_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
      else check("rd_data", 64'(rd_if.rd_data), 64'(exp_q.pop_front()));
    end
  end

  task automatic next_cycle();
    int rel;
    @(posedge clk);
    #1;
    arm = 1'b0;
    abort = 1'b0;
    force_trig = 1'b0;
    rd_if.rd_en = 1'b0;
    rel = cyc - seq_base;
    if (rand_mode) begin
      rx_data_in = 16'($urandom_range(0, 65535));
      rx_ctl_in  = 2'($urandom_range(0, 3));
    end else begin
      rx_data_in = 16'(rel);
      rx_ctl_in  = 2'(rel);
    end
  endtask

  // arm at rel 0 (data = rel); trigger sample expected at exp_rel
  task automatic run_capture(input string tag, input logic [15:0] td, input logic [15:0] tdm,
                             input logic [1:0] tc, input logic [1:0] tcm,
                             input int force_rel, input int exp_rel, input bit arm_in_post);
    int trig_seen, done_seen, arm_cyc, exp_ptr, exp_start, base;
    trig_data = td; trig_data_mask = tdm; trig_ctl = tc; trig_ctl_mask = tcm;
    seq_base = cyc + 1;
    next_cycle();
    arm_cyc = cyc;
    arm = 1'b1;
    trig_seen = -1;
    done_seen = -1;
    for (int r = 1; r <= 200 && done_seen < 0; r++) begin
      next_cycle();
      if (r == 1) check({tag, "_busy"}, 64'(busy), 64'd1);
      if (r == force_rel) force_trig = 1'b1;
      if (arm_in_post && trig_seen >= 0 && r == trig_seen + 2) arm = 1'b1;
      if (triggered && trig_seen < 0) trig_seen = r;
      if (done && done_seen < 0) done_seen = r;
    end
    check({tag, "_trig_cycle"}, 64'(trig_seen), 64'(exp_rel + 1));
    check({tag, "_done_cycle"}, 64'(done_seen), 64'(exp_rel + 1 + POST_N));
    exp_ptr   = (exp_rel - 1) % DEPTH;
    exp_start = (exp_ptr - PRE_TRIG + DEPTH) % DEPTH;
    last_start = exp_start;
    check({tag, "_start_addr"}, 64'(start_addr), 64'(exp_start));
    base = arm_cyc + exp_rel - PRE_TRIG;
    for (int i = 0; i < DEPTH; i++) begin
      next_cycle();
      rd_if.rd_en = 1'b1;
      rd_if.rd_addr = AW'(i);
      exp_q.push_back(hist[(base + i) % HN]);
    end
    next_cycle();
    next_cycle();
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst_in = 1'b1;
    arm = 1'b0; abort = 1'b0; force_trig = 1'b0;
    trig_data = '0; trig_data_mask = '0; trig_ctl = '0; trig_ctl_mask = '0;
    rx_data_in = '0; rx_ctl_in = '0;
    rd_if.rd_en = 1'b0; rd_if.rd_addr = '0;
    repeat (4) next_cycle();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_triggered", 64'(triggered), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_start_addr", 64'(start_addr), 64'd0);
    check("rst_rd_valid", 64'(rd_if.rd_valid), 64'd0);
    check("rst_rd_data", 64'(rd_if.rd_data), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    rst_in = 1'b0;
    rand_mode = 1'b0;
    next_cycle();

    run_capture("basic",   16'h0020, 16'hFFFF, 2'b00, 2'b00, -1, 32, 1'b0);
    run_capture("pregate", 16'h0002, 16'h000F, 2'b00, 2'b00, -1, 18, 1'b0);
    run_capture("wrap",    16'hFFFF, 16'hFFFF, 2'b00, 2'b00, 55, 55, 1'b0);
    run_capture("ctl",     16'h0000, 16'h0000, 2'b11, 2'b11, -1, 7,  1'b0);
    run_capture("armpost", 16'h0030, 16'hFFFF, 2'b00, 2'b00, -1, 48, 1'b1);

    // abort from DONE
    next_cycle();
    abort = 1'b1;
    next_cycle();
    check("abort_done_done", 64'(done), 64'd0);
    check("abort_done_state", 64'(state_dbg), 64'd0);

    // arm and abort together from IDLE
    next_cycle();
    arm = 1'b1;
    abort = 1'b1;
    next_cycle();
    check("armabort_busy", 64'(busy), 64'd0);
    next_cycle();
    check("armabort_state", 64'(state_dbg), 64'd0);

    // abort while ARMED keeps start_addr
    trig_data = 16'hFFFF; trig_data_mask = 16'hFFFF; trig_ctl_mask = '0;
    seq_base = cyc + 1;
    next_cycle();
    arm = 1'b1;
    repeat (8) next_cycle();
    check("abort_armed_busy_before", 64'(busy), 64'd1);
    abort = 1'b1;
    next_cycle();
    check("abort_armed_busy", 64'(busy), 64'd0);
    check("abort_armed_start", 64'(start_addr), 64'(last_start));

    // reset during POST, with a read pending in the reset cycle
    next_cycle();
    arm = 1'b1;
    for (int r = 1; r <= 9; r++) begin
      next_cycle();
      if (r == 6) force_trig = 1'b1;
    end
    check("post_state", 64'(state_dbg), 64'd3);
    rst_in = 1'b1;
    rd_if.rd_en = 1'b1;
    rd_if.rd_addr = AW'($urandom_range(0, DEPTH - 1));
    next_cycle();
    rst_in = 1'b0;
    check("rstpost_busy", 64'(busy), 64'd0);
    check("rstpost_triggered", 64'(triggered), 64'd0);
    check("rstpost_done", 64'(done), 64'd0);
    check("rstpost_start_addr", 64'(start_addr), 64'd0);
    check("rstpost_rd_valid", 64'(rd_if.rd_valid), 64'd0);
    check("rstpost_rd_data", 64'(rd_if.rd_data), 64'd0);
    repeat (3) next_cycle();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sniffer_capture.md
# sniffer_capture

PIPE-side RX sniffer for the LitePCIe link. It forwards the RX lane to the downstream core with zero latency, exactly like a plain tap. It also records the lane into an on-chip ring buffer with a configurable pre-trigger window and a masked-pattern trigger, and exposes a one-cycle-latency readout port for software or a debug bridge. It sits between the PHY RX interface and the LitePCIe core.

## Interface
- `DATA_W`, 16: RX data width.
- `CTL_W`, 2: RX control (K/valid) width.
- `DEPTH`, 512: capture entries. Must be a power of 2, ≥ 4.
- `PRE_TRIG`, 64: samples kept before the trigger sample. Range 0 … DEPTH-1.
- `clk_in`  in  1  sole clock; all logic on its rising edge.
- `rst_in`  in  1  synchronous, active-high reset.
- `rx_data_in`  in  DATA_W  RX data from the PHY.
- `rx_ctl_in`  in  CTL_W  RX control from the PHY.
- `rx_data_out`  out  DATA_W  combinational copy of `rx_data_in`.
- `rx_ctl_out`  out  CTL_W  combinational copy of `rx_ctl_in`.
- `arm`  in  1  pulse: start a capture.
- `abort`  in  1  pulse: stop the capture and return to IDLE.
- `force_trig`  in  1  trigger unconditionally while ARMED.
- `trig_data`, `trig_data_mask`  in  DATA_W  data match value and mask (mask bit 1 = compare).
- `trig_ctl`, `trig_ctl_mask`  in  CTL_W  control match value and mask.
- `busy`  out  1  state is PRE, ARMED or POST.
- `triggered`  out  1  trigger seen; sticky until the next arm or reset.
- `done`  out  1  state is DONE.
- `start_addr`  out  log2(DEPTH)  physical address of the oldest captured sample.
- `rd_en`  in  1  read request.
- `rd_addr`  in  log2(DEPTH)  read offset, relative to `start_addr`.
- `rd_valid`  out  1  `rd_data` is valid.
- `rd_data`  out  ENTRY_W  captured entry, packed as {[ts], ctl, data}.

## Operation
- Pass-through is pure wiring. It is unaffected by reset and by the capture state.
- ENTRY_W = DATA_W + CTL_W, plus 32 bits when timestamps are enabled.
- Trigger match is true when both of these hold:
  - `((rx_data_in ^ trig_data) & trig_data_mask) == 0`
  - `((rx_ctl_in ^ trig_ctl) & trig_ctl_mask) == 0`
- An all-zero mask therefore matches every sample.
- States: IDLE, PRE, ARMED, POST, DONE.
- **IDLE / DONE**
  - `arm` clears `wr_ptr`, `pre_cnt`, `post_cnt` and `triggered`, then moves to PRE.
  - Nothing is written to the buffer in these states.
- **PRE**
  - Writes the current sample at `wr_ptr` and increments it, wrapping modulo DEPTH. `pre_cnt` increments.
  - Triggers are ignored.
  - Moves to ARMED once `pre_cnt == PRE_TRIG`. With PRE_TRIG = 0, PRE lasts 0 cycles: `arm` goes straight to ARMED.
- **ARMED**
  - Writes every cycle and the pointer wraps freely.
  - On a match or `force_trig`, the current sample is written:
    - `trig_ptr` takes the value of `wr_ptr`.
    - `triggered` is set to 1.
    - The state moves to POST.
- **POST**
  - Writes DEPTH-PRE_TRIG-1 further samples, counted by `post_cnt`, then moves to DONE.
  - If DEPTH-PRE_TRIG-1 = 0, the state moves from ARMED directly to DONE.
- `start_addr` = (`trig_ptr` - PRE_TRIG) mod DEPTH. It is registered when the trigger fires.
- The buffer then holds exactly PRE_TRIG pre-trigger samples, the trigger sample at offset PRE_TRIG, and the post-trigger samples.
- `abort` in any state forces IDLE on the next edge. Buffer contents and `start_addr` are retained.
- `abort` wins over `arm` in the same cycle.
- `arm` while `busy` is ignored.
- **Read path**
  - Physical address = (`start_addr` + `rd_addr`) mod DEPTH.
  - Reads are legal in every state. The content is only meaningful in DONE.
  - A read and a write to the same address in the same cycle return the old content.

## Timing
- Pass-through latency is 0 cycles.
- A sample presented in cycle N is written at the edge ending cycle N.
- A trigger sample in cycle N gives `triggered` = 1 and state = POST (or DONE) from cycle N+1.
- `done` rises the cycle after the last post-trigger write.
- `arm` in cycle N gives `busy` = 1 from cycle N+1.
- Read latency: `rd_en` in cycle N gives `rd_valid` = 1 and `rd_data` in cycle N+1. `rd_valid` is a single-cycle pulse per request; back-to-back reads are supported.
- Reset values:
  - State = IDLE.
  - `busy`, `triggered`, `done`, `rd_valid` = 0.
  - `start_addr` = 0, `rd_data` = 0.
  - Pointers and counters = 0.
  - Buffer RAM is not reset.
- Reset asserted mid-capture returns to IDLE on the same edge. Any pending read is dropped.

## Configuration
- `SNIFFER_CAPTURE_TIMESTAMP_EN` defined:
  - A 32-bit free-running counter, cleared by `rst_in`, increments every cycle and wraps at 2^32.
  - Its value at write time is stored in `rd_data[ENTRY_W-1 -: 32]`.
- Undefined: the counter is absent and ENTRY_W = DATA_W + CTL_W.

## Test plan
- Pass-through: drive random data and control during reset and during capture. `rx_*_out` must equal `rx_*_in` in the same cycle, every cycle.
- Basic capture (DEPTH=16, PRE_TRIG=4):
  - Stimulus: feed data = cycle index; trigger on data 0x0020 with mask 0xFFFF; arm at cycle 0.
  - Required: `done` 12 cycles after the trigger.
  - Required: reading offsets 0 … 15 returns 0x001C … 0x002B; offset 4 = 0x0020.
- Pre-window gating: place the matching pattern inside the first PRE_TRIG samples after `arm`. No trigger may fire there. The first match after PRE completes must be the one captured.
- Wrap-around: hold ARMED for 3×DEPTH cycles, then `force_trig`. Check `start_addr` = (`trig_ptr` - PRE_TRIG) mod DEPTH and that the read data is contiguous.
- Control:
  - `arm` and `abort` in the same cycle: state stays IDLE.
  - `arm` during POST: ignored; `done` still arrives on schedule.
  - `rst_in` during POST: all outputs return to 0 on the next cycle.
- Timestamp build: the stored ts values of consecutive entries differ by exactly 1 (modulo 2^32). Without the macro, `rd_data` width is DATA_W + CTL_W.
